rs_issue_scheduler: RTL and testbench
=====================================

RS_ISSUE_SCHEDULER -- requirements
Module: rs_issue_scheduler

Interface
REQ-001 Parameter NUM_ENTRIES, default 16: number of reservation-station rows.
REQ-002 Parameter NUM_FU, default 3: number of functional units; the FU index is 2 bits.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
REQ-004 Allocation ports SHALL be:
- alloc_valid  in  1  rename presents an instruction.
- alloc_ready  out  1  a free row exists.
- alloc_op  in  7  opcode.
- alloc_pd  in  6  physical destination.
- alloc_ps1, alloc_ps2  in  6 each  physical source tags.
- alloc_ps1_rdy, alloc_ps2_rdy  in  1 each  source already available.
- alloc_fu  in  2  target FU.
- alloc_rob  in  4  ROB index.
REQ-005 Wakeup ports SHALL be:
- wb_valid  in  1  writeback broadcast.
- wb_tag  in  6  physical register written.
REQ-006 Issue ports, one lane per FU k, SHALL be:
- issue_valid  out  NUM_FU.
- issue_ready  in  NUM_FU.
- issue_op  out  7*NUM_FU.
- issue_pd, issue_ps1, issue_ps2  out  6*NUM_FU each.
- issue_rob  out  4*NUM_FU.
REQ-007 Control ports SHALL be:
- flush  in  1  discard all rows.
- occupancy  out  5  count of valid rows.

Function
REQ-008 alloc_ready SHALL be 1 iff at least one row is invalid at the start of the cycle and flush=0; it SHALL NOT count rows freed by a same-cycle issue.
REQ-009 An allocation (alloc_valid&alloc_ready) SHALL write the lowest-index free row, visible the next cycle.
REQ-010 An allocation with alloc_fu>=NUM_FU SHALL complete the handshake but write no row.
REQ-011 On wb_valid, every valid row whose ps1 (ps2) equals wb_tag SHALL set src1_ready (src2_ready) at the clock edge.
REQ-012 An allocating row SHALL store srcN_ready = alloc_psN_rdy OR (wb_valid AND alloc_psN==wb_tag).
REQ-013 A row SHALL be eligible for FU k iff it is valid, fu==k, and both stored ready bits are 1.
REQ-014 Each FU SHALL have a round-robin pointer rr[k]:
- the grant is the first eligible row searching rr[k], rr[k]+1, ... modulo NUM_ENTRIES;
- on an issue handshake, rr[k] <= grant+1 (wrapping 15->0).
REQ-015 issue_valid[k] and lane k's data SHALL be combinational from registered state.
REQ-016 Once issue_valid[k]=1 with issue_ready[k]=0, lane k SHALL hold a lock and present the same row every cycle until the handshake or a flush, regardless of newly eligible rows.
REQ-017 On an issue handshake, the row SHALL become invalid at the clock edge and be allocatable the following cycle; the lane lock SHALL clear.
REQ-018 Simultaneous allocation, wakeup and issue on different rows SHALL all take effect in the same cycle.
REQ-019 flush SHALL, at the clock edge:
- invalidate all rows;
- clear all locks;
- set rr[*] to 0;
- set occupancy to 0;
- take priority over allocation and issue.
REQ-020 occupancy SHALL be registered and equal the number of valid rows after the edge: +1 on an allocation, -1 per issue, range 0..16.

Reset
REQ-021 While rst=1, at each edge:
- all rows invalid;
- rr[*]=0; locks clear;
- occupancy=0.
REQ-022 While rst=1, issue_valid=0 and alloc_ready=0; alloc_ready=1 in the first cycle after rst deasserts.
REQ-023 Reset asserted mid-handshake SHALL discard pending issues without any handshake completing.

Configuration
REQ-024 Macro RS_SAME_CYCLE_WAKEUP_EN:
- defined: eligibility also counts a source whose tag matches the current wb_tag, so a row can issue in the wakeup cycle;
- undefined: such a row issues no earlier than the cycle after the wakeup.

Structure
REQ-025 Package rs_pkg SHALL hold:
- rs_entry_t (valid, op[6:0], pd[5:0], ps1[5:0], src1_ready, ps2[5:0], src2_ready, fu[1:0], rob[3:0]);
- NUM_ENTRIES, NUM_FU and the tag, opcode and ROB widths.
REQ-026 Sub-module rs_rr_picker (16-bit mask plus 4-bit pointer in; found flag plus 4-bit index out) SHALL be instantiated once per FU.

Verification
REQ-027 Reset, then alloc op=0x33, pd=40, ps1=5, ps2=6, both rdy=1, fu=0 -> next cycle issue_valid[0]=1, issue_pd[0]=40, occupancy=1.
REQ-028 Alloc ps1=33 (rdy=0), fu=1; wb_tag=33 two cycles later -> issue_valid[1] rises the cycle after the wakeup (macro undefined) or in the wakeup cycle (macro defined).
REQ-029 Fill 16 rows with fu=2, all ready -> alloc_ready=0 and occupancy=16; one issue handshake -> alloc_ready=1 the next cycle.
REQ-030 Rows 3 and 9 eligible for FU0, issue_ready[0]=0 for 3 cycles, then row 1 becomes eligible -> lane 0 keeps row 3; after the handshake it grants row 9 (rr=4), then row 1.
REQ-031 flush with 5 valid rows, an active lock and alloc_valid=1 -> next cycle occupancy=0, issue_valid=0, and no row written.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared types and widths for the reservation-station issue scheduler.
package rs_pkg;
  localparam int NUM_ENTRIES = 16;
  localparam int NUM_FU      = 3;
  localparam int TAG_W       = 6;
  localparam int OP_W        = 7;
  localparam int ROB_W       = 4;
  localparam int FU_W        = 2;
  localparam int OCC_W       = 5;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] pd;
    logic [TAG_W-1:0] ps1;
    logic             src1_ready;
    logic [TAG_W-1:0] ps2;
    logic             src2_ready;
    logic [FU_W-1:0]  fu;
    logic [ROB_W-1:0] rob;
  } rs_entry_t;
endpackage

// File: rtl/rs_issue_scheduler_rr_picker.sv
// Round-robin picker: first set bit of mask at or after ptr, wrapping to the lowest set bit.
module rs_rr_picker #(
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [N-1:0] upper;

  // Bits at or above the pointer win; otherwise fall back to the lowest set bit.
  assign upper = mask & ~((N'(1) << ptr) - N'(1));

  always_comb begin
    found = |mask;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = IW'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (upper[i]) idx = IW'(i);
    end
  end
endmodule

// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler: allocation, tag wakeup, per-FU round-robin issue with lane locks.
// Optional macro RS_SAME_CYCLE_WAKEUP_EN lets a row issue in the cycle its last source is broadcast.
module rs_issue_scheduler #(
  parameter int NUM_ENTRIES = rs_pkg::NUM_ENTRIES,
  parameter int NUM_FU      = rs_pkg::NUM_FU
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                alloc_valid,
  output logic                                alloc_ready,
  input  logic [rs_pkg::OP_W-1:0]             alloc_op,
  input  logic [rs_pkg::TAG_W-1:0]            alloc_pd,
  input  logic [rs_pkg::TAG_W-1:0]            alloc_ps1,
  input  logic [rs_pkg::TAG_W-1:0]            alloc_ps2,
  input  logic                                alloc_ps1_rdy,
  input  logic                                alloc_ps2_rdy,
  input  logic [rs_pkg::FU_W-1:0]             alloc_fu,
  input  logic [rs_pkg::ROB_W-1:0]            alloc_rob,
  input  logic                                wb_valid,
  input  logic [rs_pkg::TAG_W-1:0]            wb_tag,
  output logic [NUM_FU-1:0]                   issue_valid,
  input  logic [NUM_FU-1:0]                   issue_ready,
  output logic [NUM_FU*rs_pkg::OP_W-1:0]      issue_op,
  output logic [NUM_FU*rs_pkg::TAG_W-1:0]     issue_pd,
  output logic [NUM_FU*rs_pkg::TAG_W-1:0]     issue_ps1,
  output logic [NUM_FU*rs_pkg::TAG_W-1:0]     issue_ps2,
  output logic [NUM_FU*rs_pkg::ROB_W-1:0]     issue_rob,
  input  logic                                flush,
  output logic [rs_pkg::OCC_W-1:0]            occupancy
);
  import rs_pkg::*;

  localparam int IW = $clog2(NUM_ENTRIES);

  rs_entry_t        rows_reg     [NUM_ENTRIES];
  logic [IW-1:0]    rr_reg       [NUM_FU];
  logic [IW-1:0]    lock_idx_reg [NUM_FU];
  logic [NUM_FU-1:0] lock_reg;
  logic [OCC_W-1:0] occ_reg;

  logic [NUM_ENTRIES-1:0] free_vec, hit1, hit2, rdy1, rdy2, issued_vec;
  logic [IW-1:0]          free_idx;
  logic [IW-1:0]          grant_idx [NUM_FU];
  logic [NUM_FU-1:0]      issue_fire;
  logic [OCC_W-1:0]       issue_cnt;
  logic                   alloc_fire, alloc_write;
  rs_entry_t              new_entry;

  genvar gi;

  for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_row
    assign free_vec[gi] = ~rows_reg[gi].valid;
    assign hit1[gi] = wb_valid & rows_reg[gi].valid & (rows_reg[gi].ps1 == wb_tag);
    assign hit2[gi] = wb_valid & rows_reg[gi].valid & (rows_reg[gi].ps2 == wb_tag);
`ifdef RS_SAME_CYCLE_WAKEUP_EN
    assign rdy1[gi] = rows_reg[gi].src1_ready | hit1[gi];
    assign rdy2[gi] = rows_reg[gi].src2_ready | hit2[gi];
`else
    assign rdy1[gi] = rows_reg[gi].src1_ready;
    assign rdy2[gi] = rows_reg[gi].src2_ready;
`endif
  end

  always_comb begin
    free_idx = '0;
    for (int r = NUM_ENTRIES - 1; r >= 0; r--) begin
      if (free_vec[r]) free_idx = IW'(r);
    end
  end

  // Rows freed by a same-cycle issue are deliberately not counted as free.
  assign alloc_ready = ~rst & ~flush & (|free_vec);
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign alloc_write = alloc_fire & ({1'b0, alloc_fu} < (FU_W + 1)'(NUM_FU));

  always_comb begin
    new_entry            = '0;
    new_entry.valid      = 1'b1;
    new_entry.op         = alloc_op;
    new_entry.pd         = alloc_pd;
    new_entry.ps1        = alloc_ps1;
    new_entry.src1_ready = alloc_ps1_rdy | (wb_valid & (alloc_ps1 == wb_tag));
    new_entry.ps2        = alloc_ps2;
    new_entry.src2_ready = alloc_ps2_rdy | (wb_valid & (alloc_ps2 == wb_tag));
    new_entry.fu         = alloc_fu;
    new_entry.rob        = alloc_rob;
  end

  for (gi = 0; gi < NUM_FU; gi++) begin : g_lane
    logic [NUM_ENTRIES-1:0] elig;
    logic                   found;
    logic [IW-1:0]          pick_idx;

    always_comb begin
      elig = '0;
      for (int r = 0; r < NUM_ENTRIES; r++) begin
        elig[r] = rows_reg[r].valid & (rows_reg[r].fu == FU_W'(gi)) & rdy1[r] & rdy2[r];
      end
    end

    rs_rr_picker #(.N(NUM_ENTRIES), .IW(IW)) u_picker (
      .mask  (elig),
      .ptr   (rr_reg[gi]),
      .found (found),
      .idx   (pick_idx)
    );

    // A stalled lane keeps presenting its locked row; a locked row cannot lose eligibility.
    assign grant_idx[gi]   = lock_reg[gi] ? lock_idx_reg[gi] : pick_idx;
    assign issue_valid[gi] = ~rst & (lock_reg[gi] | found);
    assign issue_fire[gi]  = issue_valid[gi] & issue_ready[gi];

    assign issue_op [gi*OP_W  +: OP_W ] = rows_reg[grant_idx[gi]].op;
    assign issue_pd [gi*TAG_W +: TAG_W] = rows_reg[grant_idx[gi]].pd;
    assign issue_ps1[gi*TAG_W +: TAG_W] = rows_reg[grant_idx[gi]].ps1;
    assign issue_ps2[gi*TAG_W +: TAG_W] = rows_reg[grant_idx[gi]].ps2;
    assign issue_rob[gi*ROB_W +: ROB_W] = rows_reg[grant_idx[gi]].rob;
  end

  always_comb begin
    issued_vec = '0;
    issue_cnt  = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (issue_fire[k]) begin
        issued_vec[grant_idx[k]] = 1'b1;
        issue_cnt = issue_cnt + OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int r = 0; r < NUM_ENTRIES; r++) rows_reg[r].valid <= 1'b0;
      for (int k = 0; k < NUM_FU; k++) begin
        rr_reg[k]       <= '0;
        lock_idx_reg[k] <= '0;
      end
      lock_reg <= '0;
      occ_reg  <= '0;
    end else begin
      for (int r = 0; r < NUM_ENTRIES; r++) begin
        if (issued_vec[r]) rows_reg[r].valid <= 1'b0;
        if (hit1[r]) rows_reg[r].src1_ready <= 1'b1;
        if (hit2[r]) rows_reg[r].src2_ready <= 1'b1;
        if (alloc_write && (free_idx == IW'(r))) rows_reg[r] <= new_entry;
      end
      for (int k = 0; k < NUM_FU; k++) begin
        if (issue_fire[k]) begin
          rr_reg[k]   <= (grant_idx[k] == IW'(NUM_ENTRIES - 1)) ? '0 : grant_idx[k] + IW'(1);
          lock_reg[k] <= 1'b0;
        end else if (issue_valid[k]) begin
          lock_reg[k]     <= 1'b1;
          lock_idx_reg[k] <= grant_idx[k];
        end
      end
      occ_reg <= occ_reg + OCC_W'(alloc_write) - issue_cnt;
    end
  end

  assign occupancy = occ_reg;
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Scoreboard bench for rs_issue_scheduler: expected issues are queued per lane at allocation time.
module tb_rs_issue_scheduler;
  import rs_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid, alloc_ready;
  logic [6:0]  alloc_op;
  logic [5:0]  alloc_pd, alloc_ps1, alloc_ps2;
  logic        alloc_ps1_rdy, alloc_ps2_rdy;
  logic [1:0]  alloc_fu;
  logic [3:0]  alloc_rob;
  logic        wb_valid;
  logic [5:0]  wb_tag;
  logic [2:0]  issue_valid, issue_ready;
  logic [20:0] issue_op;
  logic [17:0] issue_pd, issue_ps1, issue_ps2;
  logic [11:0] issue_rob;
  logic        flush;
  logic [4:0]  occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [28:0] q0 [$];
  logic [28:0] q1 [$];
  logic [28:0] q2 [$];
  logic [28:0] got, want;

`ifdef RS_SAME_CYCLE_WAKEUP_EN
  localparam logic SAME_CYCLE = 1'b1;
`else
  localparam logic SAME_CYCLE = 1'b0;
`endif

  rs_issue_scheduler dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
    .alloc_pd(alloc_pd), .alloc_ps1(alloc_ps1), .alloc_ps2(alloc_ps2),
    .alloc_ps1_rdy(alloc_ps1_rdy), .alloc_ps2_rdy(alloc_ps2_rdy),
    .alloc_fu(alloc_fu), .alloc_rob(alloc_rob),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_pd(issue_pd), .issue_ps1(issue_ps1), .issue_ps2(issue_ps2), .issue_rob(issue_rob),
    .flush(flush), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int k, input logic [28:0] v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  function automatic int q_size(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic alloc(input logic [6:0] op, input logic [5:0] pd, input logic [5:0] ps1,
                       input logic r1, input logic [5:0] ps2, input logic r2,
                       input logic [1:0] fu, input logic [3:0] rob, input logic expect_issue);
    alloc_valid = 1'b1; alloc_op = op; alloc_pd = pd; alloc_ps1 = ps1; alloc_ps1_rdy = r1;
    alloc_ps2 = ps2; alloc_ps2_rdy = r2; alloc_fu = fu; alloc_rob = rob;
    if (expect_issue) push_exp(int'(fu), {op, pd, ps1, ps2, rob});
    $display("[TB] alloc op=0x%0h pd=%0d fu=%0d ready=%0b", op, pd, fu, alloc_ready);
    step();
    alloc_valid = 1'b0;
  endtask

  // Scoreboard: every completed issue handshake pops its lane's expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (issue_valid[k] && issue_ready[k]) begin
          got = {issue_op[k*7 +: 7], issue_pd[k*6 +: 6], issue_ps1[k*6 +: 6],
                 issue_ps2[k*6 +: 6], issue_rob[k*4 +: 4]};
          $display("[TB] issue lane=%0d pd=%0d rob=%0d", k, issue_pd[k*6 +: 6], issue_rob[k*4 +: 4]);
          check($sformatf("sb_has_entry_lane%0d", k), (q_size(k) > 0) ? 32'd1 : 32'd0, 32'd1);
          if (q_size(k) > 0) begin
            case (k)
              0: want = q0.pop_front();
              1: want = q1.pop_front();
              default: want = q2.pop_front();
            endcase
            check($sformatf("sb_issue_lane%0d", k), 32'(got), 32'(want));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; alloc_valid = 1'b0; alloc_op = '0; alloc_pd = '0; alloc_ps1 = '0; alloc_ps2 = '0;
    alloc_ps1_rdy = 1'b0; alloc_ps2_rdy = 1'b0; alloc_fu = '0; alloc_rob = '0;
    wb_valid = 1'b0; wb_tag = '0; issue_ready = '0; flush = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_alloc_ready", 32'(alloc_ready), 32'd0);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_alloc_ready", 32'(alloc_ready), 32'd1);

    // Basic ready allocation issues on lane 0 the next cycle
    alloc(7'h33, 6'd40, 6'd5, 1'b1, 6'd6, 1'b1, 2'd0, 4'd1, 1'b1);
    check("basic_issue_valid", 32'(issue_valid[0]), 32'd1);
    check("basic_issue_pd", 32'(issue_pd[5:0]), 32'd40);
    check("basic_occupancy", 32'(occupancy), 32'd1);
    issue_ready[0] = 1'b1; step(); issue_ready[0] = 1'b0;
    check("basic_drained_occ", 32'(occupancy), 32'd0);
    check("basic_drained_valid", 32'(issue_valid), 32'd0);

    // Wakeup two cycles after allocation
    alloc(7'h11, 6'd41, 6'd33, 1'b0, 6'd7, 1'b1, 2'd1, 4'd2, 1'b1);
    check("wake_wait0", 32'(issue_valid[1]), 32'd0);
    step();
    check("wake_wait1", 32'(issue_valid[1]), 32'd0);
    wb_valid = 1'b1; wb_tag = 6'd33;
    #1;
    check("wake_same_cycle", 32'(issue_valid[1]), 32'(SAME_CYCLE));
    step();
    wb_valid = 1'b0;
    check("wake_next_cycle", 32'(issue_valid[1]), 32'd1);
    issue_ready[1] = 1'b1; step(); issue_ready[1] = 1'b0;

    // Broadcast coinciding with allocation is captured into the new row
    wb_valid = 1'b1; wb_tag = 6'd44;
    alloc(7'h22, 6'd42, 6'd44, 1'b0, 6'd8, 1'b1, 2'd0, 4'd3, 1'b1);
    wb_valid = 1'b0;
    check("capture_wake_valid", 32'(issue_valid[0]), 32'd1);
    issue_ready[0] = 1'b1; step(); issue_ready[0] = 1'b0;

    // Out-of-range FU: handshake completes, nothing written
    alloc(7'h01, 6'd43, 6'd1, 1'b1, 6'd1, 1'b1, 2'd3, 4'd4, 1'b0);
    check("fu_oob_occupancy", 32'(occupancy), 32'd0);
    check("fu_oob_issue_valid", 32'(issue_valid), 32'd0);

    // Fill all rows on FU2, then drain in round-robin order
    for (int i = 0; i < 16; i++)
      alloc(7'(8'h40 + i), 6'(10 + i), 6'(i), 1'b1, 6'(i + 1), 1'b1, 2'd2, 4'(i), 1'b1);
    check("full_alloc_ready", 32'(alloc_ready), 32'd0);
    check("full_occupancy", 32'(occupancy), 32'd16);
    alloc(7'h7f, 6'd63, 6'd1, 1'b1, 6'd1, 1'b1, 2'd0, 4'd0, 1'b0);
    check("full_no_write", 32'(occupancy), 32'd16);
    issue_ready[2] = 1'b1; step(); issue_ready[2] = 1'b0;
    check("freed_alloc_ready", 32'(alloc_ready), 32'd1);
    check("freed_occupancy", 32'(occupancy), 32'd15);
    issue_ready[2] = 1'b1; repeat (15) step(); issue_ready[2] = 1'b0;
    check("drained_occupancy", 32'(occupancy), 32'd0);

    // Lock holds row 3 while row 1 wakes; then rr grants row 9, then wraps to row 1
    for (int i = 0; i < 10; i++) begin
      case (i)
        1: alloc(7'h21, 6'd21, 6'd50, 1'b0, 6'd2, 1'b1, 2'd0, 4'd1, 1'b0);
        3: alloc(7'h23, 6'd23, 6'd3, 1'b1, 6'd4, 1'b1, 2'd0, 4'd3, 1'b0);
        9: alloc(7'h29, 6'd29, 6'd9, 1'b1, 6'd10, 1'b1, 2'd0, 4'd9, 1'b0);
        default: alloc(7'h05, 6'(i), 6'd60, 1'b0, 6'd61, 1'b0, 2'd2, 4'(i), 1'b0);
      endcase
    end
    check("lock_initial_pd", 32'(issue_pd[5:0]), 32'd23);
    for (int c = 0; c < 3; c++) begin
      step();
      check("lock_stall_pd", 32'(issue_pd[5:0]), 32'd23);
    end
    wb_valid = 1'b1; wb_tag = 6'd50; step(); wb_valid = 1'b0;
    check("lock_hold_valid", 32'(issue_valid[0]), 32'd1);
    check("lock_hold_pd", 32'(issue_pd[5:0]), 32'd23);
    push_exp(0, {7'h23, 6'd23, 6'd3, 6'd4, 4'd3});
    push_exp(0, {7'h29, 6'd29, 6'd9, 6'd10, 4'd9});
    push_exp(0, {7'h21, 6'd21, 6'd50, 6'd2, 4'd1});
    issue_ready[0] = 1'b1;
    step();
    check("rr_grant_row9", 32'(issue_pd[5:0]), 32'd29);
    step();
    check("rr_wrap_row1", 32'(issue_pd[5:0]), 32'd21);
    step();
    issue_ready[0] = 1'b0;
    check("after_lock_occupancy", 32'(occupancy), 32'd7);

    // Flush with valid rows, an active lock and a pending allocation
    alloc(7'h30, 6'd30, 6'd1, 1'b1, 6'd2, 1'b1, 2'd1, 4'd5, 1'b0);
    step();
    check("pre_flush_lock", 32'(issue_valid[1]), 32'd1);
    flush = 1'b1;
    alloc_valid = 1'b1; alloc_op = 7'h55; alloc_pd = 6'd55; alloc_ps1 = 6'd1; alloc_ps1_rdy = 1'b1;
    alloc_ps2 = 6'd2; alloc_ps2_rdy = 1'b1; alloc_fu = 2'd0; alloc_rob = 4'd6;
    #1;
    check("flush_alloc_ready", 32'(alloc_ready), 32'd0);
    step();
    flush = 1'b0; alloc_valid = 1'b0;
    check("flush_occupancy", 32'(occupancy), 32'd0);
    check("flush_issue_valid", 32'(issue_valid), 32'd0);
    step();
    check("flush_no_write_valid", 32'(issue_valid), 32'd0);
    check("flush_no_write_occ", 32'(occupancy), 32'd0);

    // Reset asserted while lane 0 is ready: no handshake may complete
    alloc(7'h56, 6'd56, 6'd1, 1'b1, 6'd2, 1'b1, 2'd0, 4'd7, 1'b0);
    issue_ready[0] = 1'b1; rst = 1'b1;
    #1;
    check("rst_mid_issue_valid", 32'(issue_valid), 32'd0);
    step();
    rst = 1'b0; issue_ready[0] = 1'b0;
    #1;
    check("rst_mid_occupancy", 32'(occupancy), 32'd0);
    check("rst_mid_alloc_ready", 32'(alloc_ready), 32'd1);
    check("rst_mid_valid_after", 32'(issue_valid), 32'd0);

    for (int k = 0; k < 3; k++)
      check($sformatf("sb_empty_lane%0d", k), 32'(q_size(k)), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
